dma_read_request_gen: RTL and testbench

- Consumes one DMA chunk at a time from the transfer splitter (dma_pending / address / size / direction) and emits one 3DW PCIe Memory Read TLP per chunk on a 64-bit AXI-stream TX interface.
- Allocates a read tag per request from a local pool and reports each issued request to the completion handler.
- Returns a one-cycle dma_done pulse so the splitter can advance to the next chunk.
- Handles read chunks only; chunks with dma_dir_write=1 belong to the write-path block and are ignored here.

---
 rtl/dma_read_request_gen.sv | 214 +++++++++++++++++++++
 tb/tb_dma_read_request_gen.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_request_gen.sv
// Turns DMA read chunks into 3DW PCIe Memory Read TLPs on a 64-bit AXI-stream and
// allocates a completion tag per request from a local bitmap pool.
module dma_read_request_gen #(
  parameter int TAG_COUNT = 32,
  parameter int TAG_BITS  = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                dma_pending,
  input  logic [31:0]         dma_address_host,
  input  logic [31:0]         dma_address_device,
  input  logic [9:0]          dma_size,
  input  logic                dma_dir_write,
  output logic                dma_done,
  input  logic [15:0]         pcie_requester_id,
  output logic [63:0]         tx_tdata,
  output logic [7:0]          tx_tkeep,
  output logic                tx_tlast,
  output logic                tx_tvalid,
  input  logic                tx_tready,
  output logic                issue_valid,
  output logic [TAG_BITS-1:0] issue_tag,
  output logic [31:0]         issue_addr_device,
  output logic [9:0]          issue_len_dw,
  input  logic                tag_release_valid,
  input  logic [TAG_BITS-1:0] tag_release_tag,
  output logic [TAG_BITS:0]   tags_outstanding,
  output logic                err_tag_release
);
  localparam int CW = TAG_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR0 = 2'd1,
    S_HDR1 = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          host_q, host_d;
  logic [31:0]          dev_q, dev_d;
  logic [9:0]           len_q, len_d;
  logic [TAG_BITS-1:0]  tag_q, tag_d;
  logic [63:0]          tdata_q, tdata_d;
  logic [7:0]           tkeep_q, tkeep_d;
  logic                 tlast_q, tlast_d;
  logic                 tvalid_q, tvalid_d;
  logic                 done_q, done_d;
  logic                 issue_q, issue_d;
  logic                 err_q, err_d;
  logic [TAG_COUNT-1:0] busy_q, busy_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 free_found_s;
  logic [TAG_BITS-1:0]  free_tag_s;
  logic                 rel_ok_s;
  logic                 alloc_s;
  logic [10:0]          len_sum_s;
  logic [9:0]           len_new_s;
  logic [3:0]           last_be_s;
  logic                 read_req_s;

  assign len_sum_s  = {1'b0, dma_size} + 11'd3;
  assign len_new_s  = {1'b0, len_sum_s[10:2]};
  assign last_be_s  = (len_new_s == 10'd1) ? 4'h0 : 4'hF;
  assign read_req_s = dma_pending && !dma_dir_write;

  // Lowest free tag, and whether the release targets an allocated tag
  always_comb begin
    free_found_s = 1'b0;
    free_tag_s   = '0;
    rel_ok_s     = 1'b0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found_s = 1'b1;
        free_tag_s   = TAG_BITS'(i);
      end else begin
        rel_ok_s = rel_ok_s | (tag_release_valid && (tag_release_tag == TAG_BITS'(i)));
      end
    end
  end

  // Next-state and next-beat logic; beats are built one cycle ahead so outputs stay registered
  always_comb begin
    state_d  = state_q;
    host_d   = host_q;
    dev_d    = dev_q;
    len_d    = len_q;
    tag_d    = tag_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    done_d   = 1'b0;
    issue_d  = 1'b0;
    alloc_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_req_s && (dma_size == 10'd0)) begin
          done_d  = 1'b1;
          state_d = S_WAIT;
        end else if (read_req_s && free_found_s) begin
          alloc_s  = 1'b1;
          host_d   = dma_address_host;
          dev_d    = dma_address_device;
          len_d    = len_new_s;
          tag_d    = free_tag_s;
          tdata_d  = {pcie_requester_id, 8'(free_tag_s), last_be_s, 4'hF, 22'd0, len_new_s};
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = S_HDR0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR0: begin
        if (tx_tready) begin
          tdata_d = {32'd0, host_q[31:2], 2'b00};
          tkeep_d = 8'h0F;
          tlast_d = 1'b1;
          state_d = S_HDR1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (tx_tready) begin
          tdata_d  = 64'd0;
          tkeep_d  = 8'h00;
          tlast_d  = 1'b0;
          tvalid_d = 1'b0;
          done_d   = 1'b1;
          issue_d  = 1'b1;
          state_d  = S_WAIT;
        end else begin
          state_d = S_HDR1;
        end
      end
      // Splitter outputs are stale on the cycle after dma_done, so skip it
      S_WAIT: begin
        state_d = S_IDLE;
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Tag bitmap and outstanding count; allocation and release may coincide
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < TAG_COUNT; i++) begin
      if (alloc_s && (free_tag_s == TAG_BITS'(i))) begin
        busy_d[i] = 1'b1;
      end else if (rel_ok_s && (tag_release_tag == TAG_BITS'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    err_d   = tag_release_valid && !rel_ok_s;
    count_d = count_q + CW'(alloc_s) - CW'(rel_ok_s);
  end

  // State, latched chunk fields and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      host_q   <= 32'd0;
      dev_q    <= 32'd0;
      len_q    <= 10'd0;
      tag_q    <= '0;
      tdata_q  <= 64'd0;
      tkeep_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      issue_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      host_q   <= host_d;
      dev_q    <= dev_d;
      len_q    <= len_d;
      tag_q    <= tag_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      issue_q  <= issue_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  assign tx_tdata          = tdata_q;
  assign tx_tkeep          = tkeep_q;
  assign tx_tlast          = tlast_q;
  assign tx_tvalid         = tvalid_q;
  assign dma_done          = done_q;
  assign issue_valid       = issue_q;
  assign issue_tag         = tag_q;
  assign issue_addr_device = dev_q;
  assign issue_len_dw      = len_q;
  assign err_tag_release   = err_q;
  assign tags_outstanding  = count_q;

endmodule

// File: tb/tb_dma_read_request_gen.sv
// Self-checking bench for dma_read_request_gen with a small tag pool (4 tags) so that
// exhaustion, reuse and out-of-range releases are all reachable.
module tb_dma_read_request_gen;
  localparam int TC    = 4;
  localparam int TBITS = 3;
  localparam int CW    = TBITS + 1;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             dma_pending;
  logic [31:0]      dma_address_host;
  logic [31:0]      dma_address_device;
  logic [9:0]       dma_size;
  logic             dma_dir_write;
  logic             dma_done;
  logic [15:0]      pcie_requester_id;
  logic [63:0]      tx_tdata;
  logic [7:0]       tx_tkeep;
  logic             tx_tlast;
  logic             tx_tvalid;
  logic             tx_tready;
  logic             issue_valid;
  logic [TBITS-1:0] issue_tag;
  logic [31:0]      issue_addr_device;
  logic [9:0]       issue_len_dw;
  logic             tag_release_valid;
  logic [TBITS-1:0] tag_release_tag;
  logic [TBITS:0]   tags_outstanding;
  logic             err_tag_release;

  dma_read_request_gen #(.TAG_COUNT(TC), .TAG_BITS(TBITS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .dma_pending(dma_pending),
    .dma_address_host(dma_address_host), .dma_address_device(dma_address_device),
    .dma_size(dma_size), .dma_dir_write(dma_dir_write), .dma_done(dma_done),
    .pcie_requester_id(pcie_requester_id), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_addr_device(issue_addr_device),
    .issue_len_dw(issue_len_dw), .tag_release_valid(tag_release_valid),
    .tag_release_tag(tag_release_tag), .tags_outstanding(tags_outstanding),
    .err_tag_release(err_tag_release)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          c;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  beat_t       beat_q[$];
  logic [44:0] iss_q[$];
  bit          model_busy[TC];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Observe accepted beats and pulses half a cycle away from the active edge
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (tx_tvalid && tx_tready) beat_q.push_back('{tx_tdata, tx_tkeep, tx_tlast, cyc});
      if (issue_valid) iss_q.push_back({issue_tag, issue_addr_device, issue_len_dw});
      if (dma_done) done_cnt++;
      if (err_tag_release) err_cnt++;
    end
  end

  function automatic int lowest_free();
    for (int i = 0; i < TC; i++) if (!model_busy[i]) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < TC; i++) n += model_busy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic int len_dw(input logic [9:0] size);
    return (int'(size) + 3) / 4;
  endfunction

  // Whole TLP as {beat0 data, keep, last, beat1 data, keep, last}
  function automatic logic [145:0] exp_tlp(input logic [31:0] host, input logic [9:0] size,
                                           input logic [15:0] id, input int tag);
    logic [3:0]  lbe;
    logic [31:0] aligned;
    lbe     = (len_dw(size) == 1) ? 4'h0 : 4'hF;
    aligned = (host / 32'd4) * 32'd4;
    return {id, 8'(tag), lbe, 4'hF, 22'd0, 10'(len_dw(size)), 8'hFF, 1'b0,
            32'd0, aligned, 8'h0F, 1'b1};
  endfunction

  function automatic logic [44:0] exp_issue(input int tag, input logic [31:0] dev,
                                            input logic [9:0] size);
    return {TBITS'(tag), dev, 10'(len_dw(size))};
  endfunction

  task automatic get_tlp(output logic [145:0] v, output int c0, output int c1);
    v = '0; c0 = -1; c1 = -1;
    if (beat_q.size() >= 2) begin
      v  = {beat_q[0].d, beat_q[0].k, beat_q[0].l, beat_q[1].d, beat_q[1].k, beat_q[1].l};
      c0 = beat_q[0].c;
      c1 = beat_q[1].c;
      void'(beat_q.pop_front());
      void'(beat_q.pop_front());
    end
  endtask

  task automatic get_issue(output logic [44:0] v);
    v = '0;
    if (iss_q.size() > 0) v = iss_q.pop_front();
  endtask

  task automatic drive_chunk(input logic [31:0] h, input logic [31:0] d,
                             input logic [9:0] s, input logic w);
    dma_pending = 1'b1; dma_address_host = h; dma_address_device = d;
    dma_size = s; dma_dir_write = w;
  endtask

  // Waits for dma_done and returns just after the edge that samples it
  task automatic wait_done(input bit rnd, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge i_clk);
      if (dma_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
      if (rnd) tx_tready = ($urandom_range(0, 3) != 0);
    end
    @(posedge i_clk); #1;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_done: dma_done seen=%0b required=1 within 300 cycles", ok);
    end
  endtask

  task automatic release_tag(input int t);
    tag_release_valid = 1'b1;
    tag_release_tag   = TBITS'(t);
    @(posedge i_clk); #1;
    tag_release_valid = 1'b0;
    if (t < TC) model_busy[t] = 1'b0;
  endtask

  task automatic release_all();
    for (int i = 0; i < TC; i++) if (model_busy[i]) release_tag(i);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tdata, tx_tkeep} !== 74'd0) begin
      failures++;
      $display("FAIL reset_tx: got valid=%0b last=%0b data=%h keep=%h required all 0",
               tx_tvalid, tx_tlast, tx_tdata, tx_tkeep);
    end
    checks++;
    if ({dma_done, issue_valid, err_tag_release, tags_outstanding} !== 7'd0) begin
      failures++;
      $display("FAIL reset_status: got done=%0b issue=%0b err=%0b outstanding=%0d required 0",
               dma_done, issue_valid, err_tag_release, tags_outstanding);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic test_single();
    logic [145:0] v; logic [44:0] iv; int c0, c1, t, d0; bit ok;
    pcie_requester_id = 16'h0100; tx_tready = 1'b1;
    t = lowest_free(); model_busy[t] = 1'b1; d0 = done_cnt;
    drive_chunk(32'h1000_0000, 32'h0000_0040, 10'd128, 1'b0);
    wait_done(1'b0, ok);
    dma_pending = 1'b0;
    @(negedge i_clk); #1;
    get_tlp(v, c0, c1);
    checks++;
    if (v !== exp_tlp(32'h1000_0000, 10'd128, 16'h0100, t)) begin
      failures++;
      $display("FAIL single_tlp: got %h required %h", v, exp_tlp(32'h1000_0000, 10'd128, 16'h0100, t));
    end
    get_issue(iv);
    checks++;
    if (iv !== exp_issue(t, 32'h40, 10'd128)) begin
      failures++;
      $display("FAIL single_issue: got %h required %h", iv, exp_issue(t, 32'h40, 10'd128));
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL single_done_pulses: got %0d required 1", done_cnt - d0);
    end
    checks++;
    if (tags_outstanding !== CW'(model_count())) begin
      failures++;
      $display("FAIL single_outstanding: got %0d required %0d", tags_outstanding, model_count());
    end
    release_all();
  endtask

  task automatic test_back_to_back();
    logic [145:0] v; logic [44:0] iv; int c0, c1, prev_c1; int t[3]; bit ok;
    pcie_requester_id = 16'h0A0B; tx_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t[k] = lowest_free(); model_busy[t[k]] = 1'b1;
      drive_chunk(32'h2000 + 32'(k) * 32'h200, 32'h100 + 32'(k) * 32'h200, 10'd512, 1'b0);
      wait_done(1'b0, ok);
    end
    dma_pending = 1'b0;
    @(negedge i_clk); #1;
    checks++;
    if (tags_outstanding !== CW'(model_count())) begin
      failures++;
      $display("FAIL b2b_outstanding: got %0d required %0d", tags_outstanding, model_count());
    end
    prev_c1 = 0;
    for (int k = 0; k < 3; k++) begin
      get_tlp(v, c0, c1);
      checks++;
      if (v !== exp_tlp(32'h2000 + 32'(k) * 32'h200, 10'd512, 16'h0A0B, t[k])) begin
        failures++;
        $display("FAIL b2b_tlp%0d: got %h required %h", k, v,
                 exp_tlp(32'h2000 + 32'(k) * 32'h200, 10'd512, 16'h0A0B, t[k]));
      end
      get_issue(iv);
      checks++;
      if (iv !== exp_issue(t[k], 32'h100 + 32'(k) * 32'h200, 10'd512)) begin
        failures++;
        $display("FAIL b2b_issue%0d: got %h required %h", k, iv,
                 exp_issue(t[k], 32'h100 + 32'(k) * 32'h200, 10'd512));
      end
      if (k > 0) begin
        checks++;
        if (c0 - prev_c1 !== 3) begin
          failures++;
          $display("FAIL b2b_gap%0d: got %0d cycles between TLPs required 3", k, c0 - prev_c1);
        end
      end
      prev_c1 = c1;
    end
    release_all();
  endtask

  task automatic test_stall();
    logic [145:0] exp, v; int c0, c1, t, d0, bad; bit ok;
    pcie_requester_id = 16'h00C3; tx_tready = 1'b0;
    t = lowest_free(); model_busy[t] = 1'b1;
    exp = exp_tlp(32'h3000_0006, 10'd64, 16'h00C3, t);
    drive_chunk(32'h3000_0006, 32'h80, 10'd64, 1'b0);
    d0 = done_cnt; bad = 0;
    @(posedge i_clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast} !== {1'b1, exp[145:73]} || dma_done) bad++;
      @(posedge i_clk); #1;
    end
    tx_tready = 1'b1;
    @(posedge i_clk); #1;
    tx_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast} !== {1'b1, exp[72:0]} || dma_done) bad++;
      @(posedge i_clk); #1;
    end
    checks++;
    if (bad !== 0 || done_cnt !== d0) begin
      failures++;
      $display("FAIL stall_hold: got %0d unstable cycles, %0d early done required 0 and 0",
               bad, done_cnt - d0);
    end
    tx_tready = 1'b1;
    wait_done(1'b0, ok);
    dma_pending = 1'b0;
    get_tlp(v, c0, c1);
    checks++;
    if (v !== exp || beat_q.size() !== 0) begin
      failures++;
      $display("FAIL stall_tlp: got %h (+%0d extra beats) required %h", v, beat_q.size(), exp);
    end
    iss_q.delete();
    release_all();
  endtask

  task automatic test_tag_pool();
    logic [145:0] v; logic [44:0] iv; int c0, c1, t, d0, e0, rc; bit ok;
    pcie_requester_id = 16'h1234; tx_tready = 1'b1;
    for (int k = 0; k < TC; k++) begin
      t = lowest_free(); model_busy[t] = 1'b1;
      drive_chunk(32'h5000 + 32'(k) * 32'h40, 32'h900 + 32'(k), 10'd16, 1'b0);
      wait_done(1'b0, ok);
      get_tlp(v, c0, c1);
      get_issue(iv);
      checks++;
      if (iv !== exp_issue(t, 32'h900 + 32'(k), 10'd16)) begin
        failures++;
        $display("FAIL pool_issue%0d: got %h required %h", k, iv, exp_issue(t, 32'h900 + 32'(k), 10'd16));
      end
    end
    drive_chunk(32'h6000, 32'hA00, 10'd40, 1'b0);
    d0 = done_cnt;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk); #1;
    checks++;
    if (beat_q.size() !== 0 || done_cnt !== d0 || tags_outstanding !== CW'(TC)) begin
      failures++;
      $display("FAIL pool_stall: got beats=%0d done=%0d outstanding=%0d required 0 0 %0d",
               beat_q.size(), done_cnt - d0, tags_outstanding, TC);
    end
    @(posedge i_clk); #1;
    rc = cyc;
    release_tag(2);
    t = lowest_free(); model_busy[t] = 1'b1;
    wait_done(1'b0, ok);
    dma_pending = 1'b0;
    get_tlp(v, c0, c1);
    checks++;
    if (v !== exp_tlp(32'h6000, 10'd40, 16'h1234, t) || c0 !== rc + 2) begin
      failures++;
      $display("FAIL pool_reuse: got %h at cycle %0d required %h at cycle %0d",
               v, c0, exp_tlp(32'h6000, 10'd40, 16'h1234, t), rc + 2);
    end
    iss_q.delete();
    e0 = err_cnt;
    release_tag(2);
    @(negedge i_clk); #1;
    checks++;
    if (err_cnt !== e0 || tags_outstanding !== CW'(model_count())) begin
      failures++;
      $display("FAIL pool_release_ok: got err=%0d outstanding=%0d required 0 %0d",
               err_cnt - e0, tags_outstanding, model_count());
    end
    release_tag(2);
    @(negedge i_clk); #1;
    checks++;
    if (err_cnt - e0 !== 1 || tags_outstanding !== CW'(model_count())) begin
      failures++;
      $display("FAIL pool_double_release: got err=%0d outstanding=%0d required 1 %0d",
               err_cnt - e0, tags_outstanding, model_count());
    end
    release_tag(5);
    @(negedge i_clk); #1;
    checks++;
    if (err_cnt - e0 !== 2 || tags_outstanding !== CW'(model_count())) begin
      failures++;
      $display("FAIL pool_range_release: got err=%0d outstanding=%0d required 2 %0d",
               err_cnt - e0, tags_outstanding, model_count());
    end
    release_all();
  endtask

  task automatic test_edge_lengths();
    logic [145:0] v; logic [44:0] iv; int c0, c1, t, d0; bit ok; bit bad;
    logic [9:0] sizes[5] = '{10'd4, 10'd6, 10'd0, 10'd1023, 10'd1};
    pcie_requester_id = 16'hBEEF; tx_tready = 1'b1;
    foreach (sizes[i]) begin
      t = (sizes[i] != 10'd0) ? lowest_free() : -1;
      if (t >= 0) model_busy[t] = 1'b1;
      d0 = done_cnt;
      drive_chunk(32'h7000_0010 + 32'(i), 32'hC0 + 32'(i), sizes[i], 1'b0);
      wait_done(1'b0, ok);
      dma_pending = 1'b0;
      @(negedge i_clk); #1;
      get_tlp(v, c0, c1);
      get_issue(iv);
      checks++;
      if (sizes[i] == 10'd0) begin
        bad = (v !== 146'd0) || (iv !== 45'd0) || (done_cnt - d0 !== 1) || (tags_outstanding !== CW'(0));
        if (bad) begin
          failures++;
          $display("FAIL edge_size0: got tlp=%h issue=%h done=%0d outstanding=%0d required none/1/0",
                   v, iv, done_cnt - d0, tags_outstanding);
        end
      end else begin
        bad = (v !== exp_tlp(32'h7000_0010 + 32'(i), sizes[i], 16'hBEEF, t)) ||
              (iv !== exp_issue(t, 32'hC0 + 32'(i), sizes[i]));
        if (bad) begin
          failures++;
          $display("FAIL edge_size%0d: got %h/%h required %h/%h", sizes[i], v, iv,
                   exp_tlp(32'h7000_0010 + 32'(i), sizes[i], 16'hBEEF, t),
                   exp_issue(t, 32'hC0 + 32'(i), sizes[i]));
        end
      end
      release_all();
    end
    d0 = done_cnt;
    drive_chunk(32'h8000, 32'h10, 10'd64, 1'b1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (tx_tvalid || issue_valid) bad = 1'b1;
    end
    #1;
    checks++;
    if (bad || done_cnt !== d0 || beat_q.size() !== 0 || tags_outstanding !== CW'(0)) begin
      failures++;
      $display("FAIL edge_write_ignored: got activity=%0b done=%0d beats=%0d outstanding=%0d required 0",
               bad, done_cnt - d0, beat_q.size(), tags_outstanding);
    end
    @(posedge i_clk); #1;
    dma_pending = 1'b0; dma_dir_write = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [44:0] iv; int t; bit ok;
    pcie_requester_id = 16'h0042; tx_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      t = lowest_free(); model_busy[t] = 1'b1;
      drive_chunk(32'h9000 + 32'(k) * 32'h100, 32'h20, 10'd32, 1'b0);
      wait_done(1'b0, ok);
    end
    tx_tready = 1'b0;
    drive_chunk(32'h9800, 32'h30, 10'd32, 1'b0);
    @(posedge i_clk); #1;
    tx_tready = 1'b1;
    @(posedge i_clk); #1;
    tx_tready = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (tx_tvalid !== 1'b1 || tx_tlast !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_in_hdr1: got valid=%0b last=%0b required 1 1", tx_tvalid, tx_tlast);
    end
    @(negedge i_clk);
    checks++;
    if (tx_tvalid !== 1'b0 || tags_outstanding !== CW'(0) || dma_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_cleared: got valid=%0b outstanding=%0d done=%0b required 0",
               tx_tvalid, tags_outstanding, dma_done);
    end
    @(posedge i_clk); #1;
    dma_pending = 1'b0; tx_tready = 1'b1; i_rst = 1'b0;
    for (int i = 0; i < TC; i++) model_busy[i] = 1'b0;
    beat_q.delete(); iss_q.delete();
    t = lowest_free(); model_busy[t] = 1'b1;
    drive_chunk(32'hA000, 32'h50, 10'd8, 1'b0);
    wait_done(1'b0, ok);
    dma_pending = 1'b0;
    get_issue(iv);
    checks++;
    if (iv !== exp_issue(t, 32'h50, 10'd8) || t !== 0) begin
      failures++;
      $display("FAIL rstmid_new_tag: got %h required %h", iv, exp_issue(0, 32'h50, 10'd8));
    end
    beat_q.delete();
    release_all();
  endtask

  task automatic test_random();
    logic [145:0] v; logic [44:0] iv; int c0, c1, t, lf, rel_t, e0, bad;
    logic [9:0] size; logic [31:0] host, dev; bit do_rel, exp_err, ok;
    bad = 0;
    for (int it = 0; it < 40; it++) begin
      size = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      host = $urandom; dev = $urandom;
      pcie_requester_id = 16'($urandom);
      lf = lowest_free();
      do_rel = (lf < 0) || ($urandom_range(0, 2) == 0);
      rel_t = (lf < 0) ? int'($urandom_range(0, TC - 1)) : int'($urandom_range(0, 7));
      exp_err = do_rel && ((rel_t >= TC) || !model_busy[rel_t]);
      t = (lf >= 0) ? lf : rel_t;
      if (do_rel && !exp_err) model_busy[rel_t] = 1'b0;
      if (size != 10'd0) model_busy[t] = 1'b1;
      e0 = err_cnt;
      tx_tready = ($urandom_range(0, 3) != 0);
      drive_chunk(host, dev, size, 1'b0);
      tag_release_valid = do_rel;
      tag_release_tag = TBITS'(rel_t);
      @(posedge i_clk); #1;
      tag_release_valid = 1'b0;
      wait_done(1'b1, ok);
      tx_tready = 1'b1;
      get_tlp(v, c0, c1);
      get_issue(iv);
      checks++;
      if (size == 10'd0) begin
        if (v !== 146'd0 || iv !== 45'd0) begin
          failures++; bad++;
          $display("FAIL rand%0d_size0: got tlp=%h issue=%h required none", it, v, iv);
        end
      end else if (v !== exp_tlp(host, size, pcie_requester_id, t) ||
                   iv !== exp_issue(t, dev, size)) begin
        failures++; bad++;
        $display("FAIL rand%0d_tlp: got %h/%h required %h/%h", it, v, iv,
                 exp_tlp(host, size, pcie_requester_id, t), exp_issue(t, dev, size));
      end
      checks++;
      if (tags_outstanding !== CW'(model_count()) || (err_cnt - e0) !== int'(exp_err)) begin
        failures++; bad++;
        $display("FAIL rand%0d_pool: got outstanding=%0d err=%0d required %0d %0d", it,
                 tags_outstanding, err_cnt - e0, model_count(), exp_err);
      end
      if (bad > 5) break;
    end
    dma_pending = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; dma_pending = 1'b0; dma_address_host = 32'd0; dma_address_device = 32'd0;
    dma_size = 10'd0; dma_dir_write = 1'b0; pcie_requester_id = 16'd0; tx_tready = 1'b1;
    tag_release_valid = 1'b0; tag_release_tag = '0;
    for (int i = 0; i < TC; i++) model_busy[i] = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_tag_pool();
    test_edge_lengths();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
